// File: rtl/seg7_scan_capture.sv
// rtl/seg7_scan_capture.sv - stability-filtered capture of a multiplexed 7-segment bus into a BCD word
module seg7_scan_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  err_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  ovf_pulse
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HELD  = 2'd2
    } state_t;

    state_t                state;
    logic [7:0]            cnt;
    logic [6+DIGITS:0]     prev;
    logic [DIGITS-1:0]     mask;
    logic [DIGITS-1:0]     slot_err;
    logic [4*DIGITS-1:0]   slots;

    logic [3:0]            code;
    logic                  illegal;
    logic                  onehot;
    logic                  same;
    logic                  wr;
    logic                  complete;
    logic                  busy;
    logic [DIGITS-1:0]     mask_n;
    logic [DIGITS-1:0]     err_n;
    logic [4*DIGITS-1:0]   slots_n;

    always_comb begin
        code    = 4'hF;
        illegal = 1'b0;
        case (seg_in)
            7'b1111110: code = 4'd0;
            7'b0110000: code = 4'd1;
            7'b1101101: code = 4'd2;
            7'b1111001: code = 4'd3;
            7'b0110011: code = 4'd4;
            7'b1011011: code = 4'd5;
            7'b1011111: code = 4'd6;
            7'b1110000: code = 4'd7;
            7'b1111111: code = 4'd8;
            7'b1111011: code = 4'd9;
            default:    illegal = 1'b1;
        endcase
    end

    always_comb begin
        onehot = (dig_sel != '0) && ((dig_sel & (dig_sel - DIGITS'(1))) == '0);
        same   = ({seg_in, dig_sel} == prev);
        // The write fires on the edge that completes the STABLE_CYCLES-th identical cycle.
        wr     = (state == COUNT) && same && (({1'b0, cnt} + 9'd1) == 9'(STABLE_CYCLES));
        busy   = out_valid && !out_ready;
        mask_n  = mask;
        err_n   = slot_err;
        slots_n = slots;
        for (int i = 0; i < DIGITS; i++) begin
            if (wr && dig_sel[i]) begin
                mask_n[i]        = 1'b1;
                err_n[i]         = illegal;
                slots_n[4*i +: 4] = code;
            end
        end
        complete = wr && (&mask_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            prev      <= '0;
            mask      <= '0;
            slot_err  <= '0;
            slots     <= '0;
            bcd_out   <= '0;
            err_out   <= 1'b0;
            out_valid <= 1'b0;
            ovf_pulse <= 1'b0;
        end else begin
            prev      <= {seg_in, dig_sel};
            ovf_pulse <= 1'b0;

            case (state)
                IDLE: begin
                    if (onehot) begin
                        state <= COUNT;
                        cnt   <= 8'd1;
                    end else begin
                        cnt   <= 8'd0;
                    end
                end
                COUNT: begin
                    if (!same) begin
                        state <= onehot ? COUNT : IDLE;
                        cnt   <= onehot ? 8'd1 : 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (wr) begin
                            state <= HELD;
                        end
                    end
                end
                HELD: begin
                    if (!same) begin
                        state <= onehot ? COUNT : IDLE;
                        cnt   <= onehot ? 8'd1 : 8'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                end
            endcase

            slots <= slots_n;
            if (complete) begin
                mask     <= '0;
                slot_err <= '0;
            end else begin
                mask     <= mask_n;
                slot_err <= err_n;
            end

            // A handshake on the completion edge frees the output, so the new frame still loads.
            if (complete && !busy) begin
                bcd_out   <= slots_n;
                err_out   <= |err_n;
                out_valid <= 1'b1;
            end else if (complete) begin
                ovf_pulse <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb/tb_seg7_scan_capture.sv - self-checking bench for seg7_scan_capture
module tb_seg7_scan_capture;

    localparam logic [6:0] SEG0 = 7'b1111110;
    localparam logic [6:0] SEG1 = 7'b0110000;
    localparam logic [6:0] SEG2 = 7'b1101101;
    localparam logic [6:0] SEG3 = 7'b1111001;
    localparam logic [6:0] SEG4 = 7'b0110011;
    localparam logic [6:0] SEG5 = 7'b1011011;
    localparam logic [6:0] SEG6 = 7'b1011111;
    localparam logic [6:0] SEG7 = 7'b1110000;
    localparam logic [6:0] SEG8 = 7'b1111111;
    localparam logic [6:0] SEG9 = 7'b1111011;

    logic        clk;
    logic        rst;
    logic [6:0]  seg_in;
    logic [3:0]  dig_sel;
    logic [15:0] bcd_out;
    logic        err_out;
    logic        out_valid;
    logic        out_ready;
    logic        ovf_pulse;

    seg7_scan_capture #(.DIGITS(4), .STABLE_CYCLES(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .dig_sel   (dig_sel),
        .bcd_out   (bcd_out),
        .err_out   (err_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf_pulse (ovf_pulse)
    );

    typedef struct packed {
        logic [27:0] segs;
        logic [15:0] bcd;
        logic        err;
    } vec_t;

    vec_t        tbl [5];
    logic [16:0] exp_q [$];
    logic [16:0] e_mon;
    int          n_cmp;
    int          n_fail;
    int          n_frames;
    int          n_ovf;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic dwell(input logic [3:0] sel, input logic [6:0] seg, input int n);
        dig_sel = sel;
        seg_in  = seg;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (ovf_pulse) n_ovf++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got %h want none", bcd_out);
                end else begin
                    e_mon = exp_q.pop_front();
                    chk("frame_bcd", 32'(bcd_out), 32'(e_mon[15:0]));
                    chk("frame_err", 32'(err_out), 32'(e_mon[16]));
                    n_frames++;
                end
            end
        end
    end

    initial begin
        #100000;
        n_cmp++;
        n_fail++;
        $display("FAIL watchdog: got timeout want finish");
        summary();
        $finish;
    end

    initial begin
        n_cmp = 0; n_fail = 0; n_frames = 0; n_ovf = 0;
        rst = 1'b1; out_ready = 1'b1; dig_sel = 4'b0000; seg_in = 7'b0;
        tbl[0] = '{segs: {SEG4, SEG3, SEG2, SEG1}, bcd: 16'h4321, err: 1'b0};
        tbl[1] = '{segs: {SEG7, 7'b0000000, SEG6, SEG5}, bcd: 16'h7F65, err: 1'b1};
        tbl[2] = '{segs: {SEG1, SEG0, SEG9, SEG8}, bcd: 16'h1098, err: 1'b0};
        tbl[3] = '{segs: {SEG3, SEG3, SEG3, 7'b1000000}, bcd: 16'h333F, err: 1'b1};
        tbl[4] = '{segs: {SEG6, SEG7, SEG8, SEG9}, bcd: 16'h6789, err: 1'b0};

        #12;
        chk("reset_bcd", 32'(bcd_out), 32'h0);
        chk("reset_err", 32'(err_out), 32'h0);
        chk("reset_valid", 32'(out_valid), 32'h0);
        chk("reset_ovf", 32'(ovf_pulse), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({tbl[i].err, tbl[i].bcd});
            for (int s = 0; s < 4; s++)
                dwell(4'b0001 << s, tbl[i].segs[7*s +: 7], 3);
            chk("tbl_valid", 32'(out_valid), 32'h1);
            chk("tbl_bcd", 32'(bcd_out), 32'(tbl[i].bcd));
            chk("tbl_err", 32'(err_out), 32'(tbl[i].err));
            @(posedge clk); #1;
            chk("tbl_valid_drop", 32'(out_valid), 32'h0);
        end

        exp_q.push_back(17'h02005);
        dwell(4'b0001, SEG7, 2);
        dwell(4'b0001, SEG5, 4);
        dwell(4'b0010, SEG0, 3);
        dwell(4'b0100, SEG0, 3);
        dwell(4'b1000, SEG2, 10);
        chk("glitch_valid_drop", 32'(out_valid), 32'h0);

        exp_q.push_back(17'h04321);
        dwell(4'b0001, SEG1, 3);
        dwell(4'b0010, SEG2, 3);
        dwell(4'b0100, SEG3, 3);
        chk("long_dwell_once", 32'(out_valid), 32'h0);
        dwell(4'b0011, SEG8, 5);
        dwell(4'b0000, SEG8, 5);
        chk("idle_no_frame", 32'(out_valid), 32'h0);
        dwell(4'b1000, SEG4, 3);
        chk("idle_frame_valid", 32'(out_valid), 32'h1);
        chk("idle_frame_bcd", 32'(bcd_out), 32'h4321);
        @(posedge clk); #1;

        out_ready = 1'b0;
        exp_q.push_back(17'h00000);
        for (int s = 0; s < 4; s++) dwell(4'b0001 << s, SEG0, 3);
        chk("bp_a_valid", 32'(out_valid), 32'h1);
        chk("bp_a_bcd", 32'(bcd_out), 32'h0);
        for (int s = 0; s < 4; s++) dwell(4'b0001 << s, SEG9, 3);
        chk("bp_b_ovf", 32'(ovf_pulse), 32'h1);
        chk("bp_b_bcd", 32'(bcd_out), 32'h0);
        chk("bp_b_valid", 32'(out_valid), 32'h1);
        @(posedge clk); #1;
        chk("bp_ovf_single", 32'(ovf_pulse), 32'h0);
        exp_q.push_back(17'h01413);
        dwell(4'b0001, SEG3, 3);
        dwell(4'b0010, SEG1, 3);
        dwell(4'b0100, SEG4, 3);
        dwell(4'b1000, SEG1, 2);
        out_ready = 1'b1;
        dwell(4'b1000, SEG1, 1);
        chk("bp_c_valid", 32'(out_valid), 32'h1);
        chk("bp_c_bcd", 32'(bcd_out), 32'h1413);
        chk("bp_c_ovf", 32'(ovf_pulse), 32'h0);
        @(posedge clk); #1;

        out_ready = 1'b0;
        dwell(4'b0001, 7'b0000000, 3);
        dwell(4'b0010, SEG5, 3);
        dwell(4'b0100, SEG5, 3);
        dwell(4'b1000, SEG5, 3);
        chk("rst_pre_valid", 32'(out_valid), 32'h1);
        chk("rst_pre_bcd", 32'(bcd_out), 32'h555F);
        chk("rst_pre_err", 32'(err_out), 32'h1);
        dwell(4'b0001, SEG7, 3);
        dwell(4'b0010, SEG7, 3);
        dwell(4'b0100, SEG7, 3);
        #2;
        rst = 1'b1;
        dig_sel = 4'b0000;
        seg_in = 7'b0;
        #1;
        chk("rst_bcd", 32'(bcd_out), 32'h0);
        chk("rst_err", 32'(err_out), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_ovf", 32'(ovf_pulse), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        dwell(4'b1000, SEG6, 3);
        chk("rst_no_early_frame", 32'(out_valid), 32'h0);
        dwell(4'b0001, SEG2, 3);
        dwell(4'b0010, SEG4, 3);
        exp_q.push_back(17'h06842);
        dwell(4'b0100, SEG8, 3);
        chk("rst_frame_valid", 32'(out_valid), 32'h1);
        chk("rst_frame_bcd", 32'(bcd_out), 32'h6842);
        repeat (4) begin
            @(posedge clk); #1;
        end

        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        chk("frame_count", 32'(n_frames), 32'd10);
        chk("ovf_count", 32'(n_ovf), 32'd1);
        summary();
        $finish;
    end

endmodule

// File: doc/seg7_scan_capture.md
# seg7_scan_capture

Receive-side counterpart of the team's BCD-to-7-segment decoder. The block samples a time-multiplexed, active-high 7-segment display bus with a one-hot digit select and a shared segment bus. It filters each digit dwell for stability and maps each segment pattern back to its BCD value. Once every digit position has been captured, it presents the complete multi-digit word on a valid/ready output. It is used in display loop-back checking and in front-panel readback.

## Interface
Parameters:
- DIGITS, 4: number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 3: consecutive identical cycles required before a digit is accepted (2..255).

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- seg_in  in  7  segment bus, seg_in[6]=a … seg_in[0]=g, 1 = lit.
- dig_sel  in  DIGITS  digit select, one-hot, bit i = position i.
- bcd_out  out  4*DIGITS  captured word, bcd_out[4i+3:4i] = digit at position i.
- err_out  out  1  qualifies bcd_out: the frame contained at least one illegal pattern.
- out_valid  out  1  bcd_out/err_out hold a frame.
- out_ready  in  1  consumer accepts the frame.
- ovf_pulse  out  1  one-cycle pulse: a completed frame was dropped.

## Operation
- Pattern map (seg_in → code), legal:
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4.
  - 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9.
- Any other pattern, including 0000000, is illegal. An illegal pattern decodes to 4'hF and sets that slot's error bit.
- Stability filter, one per block, FSM with three states:
  - IDLE: dig_sel is not one-hot (zero bits or more than one bit set). The counter is held at 0.
  - COUNT: dig_sel is one-hot. The counter increments each cycle while {seg_in, dig_sel} equals the previous cycle's value.
    - On any change, the counter restarts at 1 with the new value, or the FSM goes to IDLE if the new dig_sel is not one-hot.
  - HELD: reached when the counter hits STABLE_CYCLES. The slot selected by dig_sel is written with its code and error bit, and its bit in the capture mask is set.
    - The FSM stays in HELD with no further writes until {seg_in, dig_sel} changes. It then goes to COUNT with count 1, or to IDLE.
- Each dwell causes exactly one capture, however long it lasts.
- Recapturing a slot already in the mask overwrites it; the latest value wins.
- Frame complete: the capture mask, including this cycle's write, is all ones.
  - On the same edge, the slots load into bcd_out.
  - err_out loads with the OR of the slot error bits.
  - The mask and all slot error bits clear.
- Output handshake:
  - out_valid stays high until a cycle with out_valid && out_ready.
  - bcd_out and err_out stay stable while out_valid is high.
- Output is busy when out_valid is high and out_ready is low. A frame completing in that cycle is discarded: ovf_pulse goes high for one cycle and the held output is unchanged.
- Simultaneous handshake and frame completion: the new frame loads, out_valid stays high, and there is no overflow.
- Reset, asynchronous, at any point:
  - Outputs: bcd_out=0, err_out=0, out_valid=0, ovf_pulse=0.
  - Internal: FSM=IDLE, counter=0, mask=0, slots=0, all slot error bits=0.
  - A partial frame is lost. Capture restarts from an empty mask.

## Timing
- Input stable from cycle t through t+STABLE_CYCLES-1: the slot write is on the rising edge ending cycle t+STABLE_CYCLES-1. It is visible at cycle t+STABLE_CYCLES.
- If that write completes the frame, out_valid is high at cycle t+STABLE_CYCLES, with no extra latency.
- Glitch rejection: dwells shorter than STABLE_CYCLES cycles are never captured.
- Handshake completes on the edge where out_valid && out_ready. out_valid falls the next cycle unless a new frame loads on that edge.
- ovf_pulse is registered and is high for exactly the cycle after the dropped completion edge.
- No combinational path from inputs to outputs.

## Test plan
Default parameters (DIGITS=4, STABLE_CYCLES=3) unless stated; dig_sel values are one-hot.
- Scan "1234": hold dig_sel=0001 with seg_in=0110000 (1), then 0010 with 1101101 (2), 0100 with 1111001 (3), 1000 with 0110011 (4), 3 cycles each, out_ready=1 → bcd_out=16'h4321, err_out=0, out_valid high one cycle.
- Glitch: dig_sel=0001 and seg_in for "7" held 2 cycles, then "5" held 4 cycles, then complete the frame → slot 0 = 5. A dwell of 10 cycles captures once.
- Illegal pattern: slot 2 driven with 0000000, other slots legal → bcd_out[11:8]=4'hF, err_out=1. Next clean frame → err_out=0.
- Backpressure: out_ready=0, complete frame A "0000", then complete frame B "9999" → ovf_pulse one cycle, bcd_out stays 0. Raise out_ready on the same edge as frame C completes → C loads, out_valid stays high, no ovf_pulse.
- dig_sel=0011 or 0000 for 5 cycles → no capture, FSM IDLE.
- Assert rst mid-frame after 3 slots captured → all outputs 0 immediately. The next 4 full dwells produce exactly one frame.
